// File: rtl/ldpc_min_pkg.sv
// ----------------------------------------------------------------------------
// ldpc_min_pkg
// Shared types and constants for the LDPC check-node min finder.
//   MSG_W     default message width
//   DEG       default check-node degree
//   IDX_W     width of a frame index
//   MSG_MAX   all-ones message, the "nothing seen yet" value of a running min
//   msg_t     one message
//   idx_t     one frame index
//   min_res_t result bundle {min1, min2, idx, sgn}
// ----------------------------------------------------------------------------
package ldpc_min_pkg;

  localparam int MSG_W = 11;
  localparam int DEG   = 5;
  localparam int IDX_W = $clog2(DEG);

  localparam logic [MSG_W-1:0] MSG_MAX = {MSG_W{1'b1}};

  typedef logic [MSG_W-1:0] msg_t;
  typedef logic [IDX_W-1:0] idx_t;

  typedef struct packed {
    msg_t min1;
    msg_t min2;
    idx_t idx;
    logic sgn;
  } min_res_t;

endpackage

// File: rtl/min_serial_cn_if.sv
// ----------------------------------------------------------------------------
// min_serial_cn_if
// Input stream and result handshake of the serial check-node min finder.
//   in_valid/in_ready/in_msg          message stream, one message per beat
//   out_valid/out_ready               result handshake
//   out_min1/out_min2/out_idx/out_sgn result payload
// Modports:
//   slave   the min finder itself
//   master  the environment (message source and result sink)
// ----------------------------------------------------------------------------
interface min_serial_cn_if #(
  parameter int MSG_W = ldpc_min_pkg::MSG_W,
  parameter int IDX_W = ldpc_min_pkg::IDX_W
);

  logic             in_valid;
  logic             in_ready;
  logic [MSG_W-1:0] in_msg;
  logic             out_valid;
  logic             out_ready;
  logic [MSG_W-1:0] out_min1;
  logic [MSG_W-1:0] out_min2;
  logic [IDX_W-1:0] out_idx;
  logic             out_sgn;

  modport slave (
    input  in_valid, in_msg, out_ready,
    output in_ready, out_valid, out_min1, out_min2, out_idx, out_sgn
  );

  modport master (
    output in_valid, in_msg, out_ready,
    input  in_ready, out_valid, out_min1, out_min2, out_idx, out_sgn
  );

endinterface

// File: rtl/min2_insert.sv
// ----------------------------------------------------------------------------
// min2_insert
// Combinational compare-insert of one value into a (min1, min2, idx) pair.
// Strict less-than: on a tie with min1 the incumbent keeps min1 and the newcomer
// becomes min2, so the earliest index wins.
//   i_v       candidate value
//   i_v_idx   frame index of the candidate
//   i_min1    current smallest value
//   i_min2    current second smallest value
//   i_idx     index of current smallest value
//   o_min1/o_min2/o_idx   updated pair and index
// ----------------------------------------------------------------------------
module min2_insert #(
  parameter int MSG_W = ldpc_min_pkg::MSG_W,
  parameter int IDX_W = ldpc_min_pkg::IDX_W
) (
  input  logic [MSG_W-1:0] i_v,
  input  logic [IDX_W-1:0] i_v_idx,
  input  logic [MSG_W-1:0] i_min1,
  input  logic [MSG_W-1:0] i_min2,
  input  logic [IDX_W-1:0] i_idx,
  output logic [MSG_W-1:0] o_min1,
  output logic [MSG_W-1:0] o_min2,
  output logic [IDX_W-1:0] o_idx
);

  // Insert the candidate into the ordered pair.
  always_comb begin
    o_min1 = i_min1;
    o_min2 = i_min2;
    o_idx  = i_idx;
    if (i_v < i_min1) begin
      o_min2 = i_min1;
      o_min1 = i_v;
      o_idx  = i_v_idx;
    end else if (i_v < i_min2) begin
      o_min2 = i_v;
    end else begin
      o_min1 = i_min1;
    end
  end

endmodule

// File: rtl/min_serial_cn.sv
// ----------------------------------------------------------------------------
// min_serial_cn
// Streaming check-node min finder. Takes DEG messages of one check node, one per
// accepted beat, and presents min1, min2 and the index of min1 one cycle after
// the last beat. Back-pressured on both sides; the next frame may start in the
// cycle after a frame's last beat.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   min_serial_cn_if.slave (input stream + result handshake)
// Configuration macro:
//   MIN_SIGN_EN  messages are sign-magnitude; compare on magnitude and report
//                the XOR of all signs on out_sgn. Undefined: unsigned compare of
//                the full message, out_sgn tied 0.
// ----------------------------------------------------------------------------
module min_serial_cn #(
  parameter int MSG_W = ldpc_min_pkg::MSG_W,
  parameter int DEG   = ldpc_min_pkg::DEG,
  parameter int IDX_W = $clog2(DEG)
) (
  input  logic          clk,
  input  logic          rst,
  min_serial_cn_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEG - 1);
  localparam logic [MSG_W-1:0] RUN_INIT = {MSG_W{1'b1}};

  logic [IDX_W-1:0] r_cnt;
  logic [MSG_W-1:0] r_run_min1;
  logic [MSG_W-1:0] r_run_min2;
  logic [IDX_W-1:0] r_run_idx;

  logic             r_out_valid;
  logic [MSG_W-1:0] r_out_min1;
  logic [MSG_W-1:0] r_out_min2;
  logic [IDX_W-1:0] r_out_idx;
  logic             r_out_sgn;

  logic [MSG_W-1:0] w_v;
  logic             w_frame_sgn;
  logic             w_last;
  logic             w_beat;
  logic [MSG_W-1:0] w_ins_min1;
  logic [MSG_W-1:0] w_ins_min2;
  logic [IDX_W-1:0] w_ins_idx;

`ifdef MIN_SIGN_EN
  logic r_run_sgn;

  // Compare on magnitude only; the sign accumulates separately.
  assign w_v         = {1'b0, bus.in_msg[MSG_W-2:0]};
  assign w_frame_sgn = r_run_sgn ^ bus.in_msg[MSG_W-1];

  // Running sign XOR, cleared at every frame boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run_sgn <= 1'b0;
    end else if (w_beat) begin
      r_run_sgn <= w_last ? 1'b0 : w_frame_sgn;
    end
  end
`else
  assign w_v         = bus.in_msg;
  assign w_frame_sgn = 1'b0;
`endif

  assign w_last = (r_cnt == LAST_IDX);

  // Only the last beat can be blocked: it is the one that overwrites the result.
  assign bus.in_ready = !(w_last && r_out_valid && !bus.out_ready);
  assign w_beat       = bus.in_valid && bus.in_ready;

  min2_insert #(
    .MSG_W (MSG_W),
    .IDX_W (IDX_W)
  ) u_insert (
    .i_v     (w_v),
    .i_v_idx (r_cnt),
    .i_min1  (r_run_min1),
    .i_min2  (r_run_min2),
    .i_idx   (r_run_idx),
    .o_min1  (w_ins_min1),
    .o_min2  (w_ins_min2),
    .o_idx   (w_ins_idx)
  );

  // Beat counter and running minima; re-armed on the frame's last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_run_min1 <= RUN_INIT;
      r_run_min2 <= RUN_INIT;
      r_run_idx  <= '0;
    end else if (w_beat) begin
      if (w_last) begin
        r_cnt      <= '0;
        r_run_min1 <= RUN_INIT;
        r_run_min2 <= RUN_INIT;
        r_run_idx  <= '0;
      end else begin
        r_cnt      <= r_cnt + IDX_W'(1);
        r_run_min1 <= w_ins_min1;
        r_run_min2 <= w_ins_min2;
        r_run_idx  <= w_ins_idx;
      end
    end
  end

  // Result registers: load on frame completion, otherwise drain on out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_min1  <= '0;
      r_out_min2  <= '0;
      r_out_idx   <= '0;
      r_out_sgn   <= 1'b0;
    end else if (w_beat && w_last) begin
      r_out_valid <= 1'b1;
      r_out_min1  <= w_ins_min1;
      r_out_min2  <= w_ins_min2;
      r_out_idx   <= w_ins_idx;
      r_out_sgn   <= w_frame_sgn;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_min1  = r_out_min1;
  assign bus.out_min2  = r_out_min2;
  assign bus.out_idx   = r_out_idx;
  assign bus.out_sgn   = r_out_sgn;

endmodule
